// File: rtl/mole_pkg.sv
// Shared types and constants for the mole responder: FSM states, LFSR taps, default windows.
// Pure declarations, so there is no latency and no backpressure.
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_GRANT,
    ST_WINDOW,
    ST_EXPIRED
  } mole_state_t;

  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_WINDOW_EASY = 75_000_000;
  localparam int DEF_WINDOW_HARD = 25_000_000;
  localparam int DEF_SHRINK_STEP = 1_000_000;
  localparam int DEF_WINDOW_MIN  = 10_000_000;

endpackage

// File: rtl/mole_responder_lfsr16.sv
// Free-running 16-bit Galois LFSR that advances every cycle and restarts from seed on reset.
// Latency: the new value appears one cycle after each step; there is no backpressure.
module lfsr16
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/mole_responder.sv
// Picks a non-repeating mole on ready_for_mole, gives rng_ready two cycles later, then holds timeout while the window runs.
// No backpressure: the game FSM's levels drive everything. SHRINK_WINDOW_EN makes each level's window shrink after every mole.
module mole_responder
  import mole_pkg::*;
#(
  parameter int          N_MOLES     = 8,
  parameter int          WINDOW_EASY = DEF_WINDOW_EASY,
  parameter int          WINDOW_HARD = DEF_WINDOW_HARD,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
`ifdef SHRINK_WINDOW_EN
  ,
  parameter int          SHRINK_STEP = DEF_SHRINK_STEP,
  parameter int          WINDOW_MIN  = DEF_WINDOW_MIN
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ready_for_mole,
  input  logic                       timeout_start,
  input  logic                       level_select,
  output logic                       rng_ready,
  output logic                       timeout,
  output logic [$clog2(N_MOLES)-1:0] mole_idx,
  output logic [N_MOLES-1:0]         mole_onehot
);

  localparam int IW   = $clog2(N_MOLES);
  localparam int WMAX = (WINDOW_EASY > WINDOW_HARD) ? WINDOW_EASY : WINDOW_HARD;
  localparam int CW   = $clog2(WMAX + 1);

  mole_state_t   state, state_nxt;
  logic [15:0]   lfsr;
  logic [IW-1:0] cand;
  logic [CW-1:0] counter;
  logic [CW-1:0] win_load;
  logic          have_last;
  logic          leds_on;
  logic          lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Only the low bits pick the mole; the rest of the LFSR just supplies the sequence.
  assign lfsr_unused = ^lfsr[15:IW];

  always_comb begin
    cand = lfsr[IW-1:0];
    if (have_last && cand == mole_idx) begin
      cand = cand + 1'b1;
    end
  end

`ifdef SHRINK_WINDOW_EN
  logic [CW-1:0] cur_win_easy, cur_win_hard;
  logic          pick_hard;

  function automatic logic [CW-1:0] shrink(input logic [CW-1:0] w);
    if (int'(w) >= WINDOW_MIN + SHRINK_STEP) begin
      return w - CW'(SHRINK_STEP);
    end
    return CW'(WINDOW_MIN);
  endfunction

  assign win_load = level_select ? cur_win_hard : cur_win_easy;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_win_easy <= CW'(WINDOW_EASY);
      cur_win_hard <= CW'(WINDOW_HARD);
      pick_hard    <= 1'b0;
    end else begin
      if (state == ST_PICK) begin
        pick_hard <= level_select;
      end
      if (state == ST_GRANT) begin
        if (pick_hard) begin
          cur_win_hard <= shrink(cur_win_hard);
        end else begin
          cur_win_easy <= shrink(cur_win_easy);
        end
      end
    end
  end
`else
  assign win_load = level_select ? CW'(WINDOW_HARD) : CW'(WINDOW_EASY);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rng_ready = 1'b0;
    timeout   = 1'b0;
    leds_on   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ready_for_mole) begin
          state_nxt = ST_PICK;
        end
      end
      ST_PICK: begin
        state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        rng_ready = 1'b1;
        timeout   = 1'b1;
        leds_on   = 1'b1;
        state_nxt = ST_WINDOW;
      end
      ST_WINDOW: begin
        timeout = 1'b1;
        leds_on = 1'b1;
        if (!timeout_start) begin
          state_nxt = ST_IDLE;
        end else if (counter == CW'(1)) begin
          state_nxt = ST_EXPIRED;
        end
      end
      ST_EXPIRED: begin
        leds_on = 1'b1;
        if (!timeout_start) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter holds the remaining WINDOW cycles including the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      mole_idx  <= '0;
      have_last <= 1'b0;
      counter   <= '0;
    end else begin
      case (state)
        ST_PICK: begin
          mole_idx  <= cand;
          have_last <= 1'b1;
          counter   <= win_load;
        end
        ST_WINDOW: begin
          if (timeout_start) begin
            counter <= counter - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mole_onehot = leds_on ? ({{(N_MOLES-1){1'b0}}, 1'b1} << mole_idx) : '0;

endmodule
